xpeakdetect: RTL and testbench

- Event detector directly downstream of the slide-window accumulator.
- Consumes the accumulator's sliding-sum stream (its o_dv drives i_nd here) and applies hi/lo hysteresis thresholds with an NHOLD-sample debounce.
- Per detected event, reports the peak sum, the peak's offset within the event, and the event length as a one-cycle report strobe.
- Feeds the control/logging logic that acts on energy bursts.

---
 rtl/xpeakdetect_pkg.sv | 20 ++
 rtl/xpeakdetect_if.sv | 25 ++
 rtl/xpeakdetect_runqual.sv | 39 +++
 rtl/xpeakdetect.sv | 137 +++++++++++++
 tb/tb_xpeakdetect.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/xpeakdetect_pkg.sv
// rtl/xpeakdetect_pkg.sv - shared state encoding and width helper for the peak detector
package xpeakdetect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } pd_state_e;

    function automatic int pd_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/xpeakdetect_if.sv
// rtl/xpeakdetect_if.sv - sample stream, thresholds and event report bundle
interface xpeakdetect_if #(
    parameter int BWID   = 22,
    parameter int NLEN_W = 16
);
    logic [BWID-1:0]   iv_data;
    logic              i_nd;
    logic [BWID-1:0]   iv_thr_hi;
    logic [BWID-1:0]   iv_thr_lo;
    logic [BWID-1:0]   ov_peak;
    logic [NLEN_W-1:0] ov_peak_idx;
    logic [NLEN_W-1:0] ov_len;
    logic              o_dv;
    logic              o_active;

    modport master (
        output iv_data, i_nd, iv_thr_hi, iv_thr_lo,
        input  ov_peak, ov_peak_idx, ov_len, o_dv, o_active
    );

    modport slave (
        input  iv_data, i_nd, iv_thr_hi, iv_thr_lo,
        output ov_peak, ov_peak_idx, ov_len, o_dv, o_active
    );
endinterface

// File: rtl/xpeakdetect_runqual.sv
// rtl/xpeakdetect_runqual.sv - consecutive-qualifier run counter, shared by arm and release runs
module xrunqual
    import xpeakdetect_pkg::*;
#(
    parameter int NHOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic step_i,
    input  logic qualify_i,
    input  logic clear_i,
    output logic done_o
);
    localparam int CW = pd_clog2(NHOLD + 1);
    localparam logic [CW-1:0] HOLD = CW'(NHOLD);

    logic [CW-1:0] cnt_q, cnt_d, base;

    // clear_i makes the current step the first sample of a fresh run
    always_comb begin
        base   = clear_i ? '0 : cnt_q;
        cnt_d  = cnt_q;
        done_o = 1'b0;
        if (step_i) begin
            if (!qualify_i) begin
                cnt_d = '0;
            end else begin
                cnt_d  = (base >= HOLD) ? HOLD : base + 1'b1;
                done_o = (cnt_d == HOLD);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/xpeakdetect.sv
// rtl/xpeakdetect.sv - hysteresis event detector reporting peak, peak offset and event length
module xpeakdetect
    import xpeakdetect_pkg::*;
#(
    parameter int BWID   = 22,
    parameter int NHOLD  = 4,
    parameter int NLEN_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    xpeakdetect_if.slave  bus
);
    localparam logic [NLEN_W-1:0] LEN_MAX = '1;

    pd_state_e state_q, state_d;

    logic [NLEN_W-1:0]      len_q, len_d, idx_q, idx_d, len_inc;
    logic [NLEN_W-1:0]      rep_len_q, rep_idx_q;
    logic signed [BWID-1:0] smp, thr_hi, thr_lo;
    logic signed [BWID-1:0] peak_q, peak_d, rep_peak_q;
    logic                   above, below, greater, report;
    logic                   rq_qual, rq_clear, rq_done;
    logic                   dv_q, active_q;

    assign smp     = $signed(bus.iv_data);
    assign thr_hi  = $signed(bus.iv_thr_hi);
    assign thr_lo  = $signed(bus.iv_thr_lo);
    assign above   = smp > thr_hi;
    assign below   = smp < thr_lo;
    assign greater = smp > peak_q;
    assign len_inc = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;

    xrunqual #(.NHOLD(NHOLD)) u_runqual (
        .clk       (clk),
        .rst       (rst),
        .step_i    (bus.i_nd),
        .qualify_i (rq_qual),
        .clear_i   (rq_clear),
        .done_o    (rq_done)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        peak_d   = peak_q;
        rq_qual  = 1'b0;
        rq_clear = 1'b0;
        report   = 1'b0;

        // Offset of the current sample is the pre-increment length, which saturates with len
        if (bus.i_nd && state_q != ST_IDLE) begin
            len_d = len_inc;
            if (greater) begin
                peak_d = smp;
                idx_d  = len_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                rq_qual  = above;
                rq_clear = 1'b1;
                if (bus.i_nd && above) begin
                    len_d   = NLEN_W'(1);
                    idx_d   = '0;
                    peak_d  = smp;
                    state_d = rq_done ? ST_ACTIVE : ST_ARM;
                end
            end
            ST_ARM: begin
                rq_qual = above;
                if (bus.i_nd) begin
                    if (!above)       state_d = ST_IDLE;
                    else if (rq_done) state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                rq_qual  = below;
                rq_clear = 1'b1;
                if (bus.i_nd && below) begin
                    if (rq_done) begin
                        report  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                rq_qual = below;
                if (bus.i_nd) begin
                    if (!below) begin
                        state_d = ST_ACTIVE;
                    end else if (rq_done) begin
                        report  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            peak_q     <= '0;
            rep_len_q  <= '0;
            rep_idx_q  <= '0;
            rep_peak_q <= '0;
            dv_q       <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            peak_q   <= peak_d;
            dv_q     <= report;
            active_q <= (state_d == ST_ACTIVE) || (state_d == ST_RELEASE);
            if (report) begin
                rep_len_q  <= len_d;
                rep_idx_q  <= idx_d;
                rep_peak_q <= peak_d;
            end
        end
    end

    assign bus.ov_peak     = rep_peak_q;
    assign bus.ov_peak_idx = rep_idx_q;
    assign bus.ov_len      = rep_len_q;
    assign bus.o_dv        = dv_q;
    assign bus.o_active    = active_q;

endmodule

// File: tb/tb_xpeakdetect.sv
// tb/tb_xpeakdetect.sv - directed and randomized checks of xpeakdetect against a sequence-level model
module tb_xpeakdetect;
    localparam int BWID = 22;
    localparam int NH   = 3;
    localparam int SMAX = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xpeakdetect_if #(.BWID(BWID), .NLEN_W(16)) ifa ();
    xpeakdetect_if #(.BWID(BWID), .NLEN_W(4))  ifb ();

    xpeakdetect #(.BWID(BWID), .NHOLD(NH), .NLEN_W(16)) u_dut (.clk(clk), .rst(rst), .bus(ifa));
    xpeakdetect #(.BWID(BWID), .NHOLD(NH), .NLEN_W(4))  u_sat (.clk(clk), .rst(rst), .bus(ifb));

    int n_pass = 0;
    int n_chk  = 0;

    int q_smp[$];
    int e_dv[$], e_act[$], e_pk[$], e_idx[$], e_len[$];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Scans the whole sample list for events: NH aboves in a row open one,
    // the first later window of NH consecutive belows closes it.
    task automatic model_run(input int hi, input int lo);
        int n, i, s, k, j, run, a, pk, pi;
        bit found;
        n = q_smp.size();
        e_dv.delete(); e_act.delete(); e_pk.delete(); e_idx.delete(); e_len.delete();
        for (int m = 0; m < n; m++) begin
            e_dv.push_back(0); e_act.push_back(0);
            e_pk.push_back(0); e_idx.push_back(0); e_len.push_back(0);
        end
        i = 0;
        while (i < n) begin
            if (!(q_smp[i] > hi)) begin
                i++;
                continue;
            end
            s = i;
            k = 0;
            while (k < NH && s + k < n && q_smp[s + k] > hi) k++;
            if (k < NH) begin
                i = s + k + 1;
                continue;
            end
            j = s + NH;
            run = 0;
            found = 1'b0;
            while (j < n && !found) begin
                if (q_smp[j] < lo) run++;
                else run = 0;
                if (run == NH) found = 1'b1;
                else j++;
            end
            for (a = s + NH - 1; a < (found ? j : n); a++) e_act[a] = 1;
            if (!found) break;
            pk = q_smp[s];
            pi = 0;
            for (a = s; a <= j; a++) begin
                if (q_smp[a] > pk) begin
                    pk = q_smp[a];
                    pi = a - s;
                end
            end
            e_dv[j]  = 1;
            e_pk[j]  = pk;
            e_idx[j] = pi;
            e_len[j] = j - s + 1;
            i = j + 1;
        end
        for (a = 1; a < n; a++) begin
            if (!e_dv[a]) begin
                e_pk[a]  = e_pk[a - 1];
                e_idx[a] = e_idx[a - 1];
                e_len[a] = e_len[a - 1];
            end
        end
    endtask

    task automatic check_at(input int k, input bit gap, input string tag);
        int x_dv, x_act, x_pk, x_idx, x_len;
        x_dv = 0; x_act = 0; x_pk = 0; x_idx = 0; x_len = 0;
        if (k >= 0) begin
            x_dv  = gap ? 0 : e_dv[k];
            x_act = e_act[k];
            x_pk  = e_pk[k];
            x_idx = e_idx[k];
            x_len = e_len[k];
        end
        check({tag, ".dv"},       int'(ifa.o_dv),              x_dv);
        check({tag, ".active"},   int'(ifa.o_active),          x_act);
        check({tag, ".peak"},     int'($signed(ifa.ov_peak)),  x_pk);
        check({tag, ".idx"},      int'(ifa.ov_peak_idx),       x_idx);
        check({tag, ".len"},      int'(ifa.ov_len),            x_len);
        check({tag, ".s_dv"},     int'(ifb.o_dv),              x_dv);
        check({tag, ".s_active"}, int'(ifb.o_active),          x_act);
        check({tag, ".s_peak"},   int'($signed(ifb.ov_peak)),  x_pk);
        check({tag, ".s_idx"},    int'(ifb.ov_peak_idx),       imin(x_idx, SMAX));
        check({tag, ".s_len"},    int'(ifb.ov_len),            imin(x_len, SMAX));
    endtask

    task automatic drive(input int v, input logic nd);
        ifa.iv_data = BWID'(v);
        ifb.iv_data = BWID'(v);
        ifa.i_nd    = nd;
        ifb.i_nd    = nd;
    endtask

    task automatic set_thr(input int hi, input int lo);
        ifa.iv_thr_hi = BWID'(hi);
        ifb.iv_thr_hi = BWID'(hi);
        ifa.iv_thr_lo = BWID'(lo);
        ifb.iv_thr_lo = BWID'(lo);
    endtask

    task automatic do_reset(input string tag);
        drive(0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_at(-1, 1'b1, tag);
    endtask

    // gap_mode: 0 none, 1 one idle cycle before every sample, 2 random idle cycles
    task automatic play(input int hi, input int lo, input int gap_mode, input string tag);
        int ngap;
        model_run(hi, lo);
        set_thr(hi, lo);
        for (int i = 0; i < q_smp.size(); i++) begin
            ngap = 0;
            if (gap_mode == 1) ngap = 1;
            else if (gap_mode == 2 && $urandom_range(0, 2) == 0) ngap = int'($urandom_range(1, 2));
            for (int g = 0; g < ngap; g++) begin
                drive(12345, 1'b0);
                @(posedge clk); #1;
                check_at(i - 1, 1'b1, {tag, ".gap"});
            end
            drive(q_smp[i], 1'b1);
            @(posedge clk); #1;
            drive(0, 1'b0);
            check_at(i, 1'b0, tag);
        end
    endtask

    function automatic int gen_smp(input int kind);
        case (kind)
            0:       return int'($urandom_range(101, 300));
            1:       return 49 - int'($urandom_range(0, 200));
            2:       return int'($urandom_range(50, 100));
            default: begin
                case ($urandom_range(0, 3))
                    0:       return 100;
                    1:       return 101;
                    2:       return 50;
                    default: return 49;
                endcase
            end
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        drive(0, 1'b0);
        set_thr(100, 50);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_at(-1, 1'b1, "reset");
        rst = 1'b0;

        q_smp = '{0, 120, 130, 140, 90, 40, 30, 20};
        play(100, 50, 0, "t1");
        check("t1.peak_k", int'($signed(ifa.ov_peak)), 140);
        check("t1.idx_k",  int'(ifa.ov_peak_idx), 2);
        check("t1.len_k",  int'(ifa.ov_len), 7);

        do_reset("t2.rst");
        q_smp = '{120, 130, 90, 0};
        play(100, 50, 0, "t2");

        do_reset("t3.rst");
        q_smp = '{120, 130, 140, 40, 30, 60, 40, 30, 20};
        play(100, 50, 0, "t3");
        check("t3.len_k", int'(ifa.ov_len), 9);

        do_reset("t4.rst");
        q_smp = '{-5, -3, -1, -60, -70, -80};
        play(-10, -50, 0, "t4");
        check("t4.peak_k", int'($signed(ifa.ov_peak)), -1);
        check("t4.idx_k",  int'(ifa.ov_peak_idx), 2);
        check("t4.len_k",  int'(ifa.ov_len), 6);

        do_reset("t5.rst");
        q_smp.delete();
        for (int i = 0; i < 20; i++) q_smp.push_back(gen_smp(0));
        for (int i = 0; i < 3; i++) q_smp.push_back(10 - i);
        play(100, 50, 1, "t5");
        check("t5.s_len_k", int'(ifb.ov_len), 15);
        check("t5.len_k",   int'(ifa.ov_len), 23);

        do_reset("t6.rst0");
        q_smp = '{120, 130, 140, 90};
        play(100, 50, 0, "t6.pre");
        check("t6.active_pre", int'(ifa.o_active), 1);
        do_reset("t6.rst");
        q_smp = '{0, 120, 130, 140, 90, 40, 30, 20};
        play(100, 50, 0, "t6");
        check("t6.peak_k", int'($signed(ifa.ov_peak)), 140);
        check("t6.idx_k",  int'(ifa.ov_peak_idx), 2);
        check("t6.len_k",  int'(ifa.ov_len), 7);

        for (int r = 0; r < 7; r++) begin
            do_reset("rnd.rst");
            q_smp.delete();
            while (q_smp.size() < 40) begin
                int kind, seg;
                kind = int'($urandom_range(0, 3));
                seg  = int'($urandom_range(1, 5));
                for (int m = 0; m < seg; m++) q_smp.push_back(gen_smp(kind));
            end
            if (r == 6) play(50, 100, 2, "rnd.swap");
            else        play(100, 50, 2, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
